// File: rtl/pkt_pattern_gen.sv
// Self-test pattern generator for the packet-control path.
// Drives LANES x (SPL x SW-bit) samples into the self-test/ADC data selector
// with fixed, ramp, PRBS9 or walking-one patterns. Every output is registered;
// the pattern for a cycle is built from the generator state as it will be
// after that cycle's update, so a restart shows the seed pattern immediately.
module pkt_pattern_gen #(
    parameter int          LANES     = 24,
    parameter int          SPL       = 4,
    parameter int          SW        = 9,
    parameter logic [SW-1:0] PRBS_SEED = 9'h1FF
) (
    input  logic                     pktctrl_clk,
    input  logic                     pktctrl_rstn,
    input  logic                     rf_self_test_mode,
    input  logic                     rf_96path_en,
    input  logic [1:0]               rf_pattern_sel,
    input  logic [SW-1:0]            rf_pattern_fixed,
    input  logic [SW-1:0]            rf_ramp_step,
    input  logic                     rf_pattern_hold,
    output logic [LANES*SPL*SW-1:0]  pkt_gen_data,
    output logic                     pkt_gen_valid,
    output logic [15:0]              pkt_gen_cnt
);

    localparam int NPATH      = LANES * SPL;
    localparam int HALF_LANES = LANES / 2;
    localparam logic [SW-1:0] ONEHOT_INIT = {{(SW-1){1'b0}}, 1'b1};

    localparam logic [1:0] SEL_FIXED = 2'd0;
    localparam logic [1:0] SEL_RAMP  = 2'd1;
    localparam logic [1:0] SEL_PRBS  = 2'd2;

    logic [1:0]              sel_q;
    logic                    en_q;
    logic [SW-1:0]           base;
    logic [SW-1:0]           lfsr;
    logic [SW-1:0]           onehot;

    logic [SW-1:0]           base_n;
    logic [SW-1:0]           lfsr_n;
    logic [SW-1:0]           onehot_n;
    logic [15:0]             cnt_n;
    logic [LANES*SPL*SW-1:0] data_n;

    logic                    restart;
    logic                    advance;

    // Restart wins over hold: a fresh enable or a pattern switch always reseeds.
    assign restart = rf_self_test_mode & (~en_q | (rf_pattern_sel != sel_q));
    assign advance = rf_self_test_mode & ~restart & ~rf_pattern_hold;

    // Generator next state: reload on restart, step on advance, otherwise hold.
    always_comb begin
        base_n   = base;
        lfsr_n   = lfsr;
        onehot_n = onehot;
        cnt_n    = pkt_gen_cnt;
        if (restart) begin
            base_n   = '0;
            lfsr_n   = PRBS_SEED;
            onehot_n = ONEHOT_INIT;
            cnt_n    = '0;
        end else if (advance) begin
            base_n   = base + rf_ramp_step;
            // x^9 + x^5 + 1, maximal length 511
            lfsr_n   = {lfsr[SW-2:0], lfsr[SW-1] ^ lfsr[SW-5]};
            onehot_n = {onehot[SW-2:0], onehot[SW-1]};
            cnt_n    = pkt_gen_cnt + 16'd1;
        end
    end

    // Per-path sample values from the post-update state, with upper-lane masking.
    always_comb begin
        data_n = '0;
        if (rf_self_test_mode) begin
            for (int p = 0; p < NPATH; p++) begin
                if (((p / SPL) < HALF_LANES) || rf_96path_en) begin
                    case (rf_pattern_sel)
                        SEL_FIXED: data_n[p*SW +: SW] = rf_pattern_fixed;
                        SEL_RAMP:  data_n[p*SW +: SW] = base_n + SW'(p);
                        SEL_PRBS:  data_n[p*SW +: SW] = lfsr_n ^ SW'(p);
                        default:   data_n[p*SW +: SW] = onehot_n;
                    endcase
                end
            end
        end
    end

    // State and output registers; outputs clear while disabled but state is kept.
    always_ff @(posedge pktctrl_clk or negedge pktctrl_rstn) begin
        if (!pktctrl_rstn) begin
            sel_q         <= 2'd0;
            en_q          <= 1'b0;
            base          <= '0;
            lfsr          <= PRBS_SEED;
            onehot        <= ONEHOT_INIT;
            pkt_gen_cnt   <= 16'd0;
            pkt_gen_valid <= 1'b0;
            pkt_gen_data  <= '0;
        end else begin
            sel_q         <= rf_pattern_sel;
            en_q          <= rf_self_test_mode;
            base          <= base_n;
            lfsr          <= lfsr_n;
            onehot        <= onehot_n;
            pkt_gen_cnt   <= cnt_n;
            pkt_gen_valid <= rf_self_test_mode;
            pkt_gen_data  <= data_n;
        end
    end

endmodule

// File: tb/tb_pkt_pattern_gen.sv
// Bench for pkt_pattern_gen: directed scenarios plus randomized traffic,
// checked against a reference model that tracks advances since the last
// restart and derives each pattern from that count with plain arithmetic.
module tb_pkt_pattern_gen;

    logic         clk;
    logic         rstn;
    logic         mode;
    logic         en96;
    logic [1:0]   sel;
    logic [8:0]   fixed;
    logic [8:0]   step;
    logic         hold;
    logic [863:0] data;
    logic         valid;
    logic [15:0]  cnt;

    int n_chk;
    int n_pass;

    // reference model
    int           prbs_tab [511];
    int           m_n;
    int           m_base;
    int           m_cnt;
    bit           m_en_q;
    logic [1:0]   m_sel_q;
    logic [863:0] exp_data;
    logic         exp_valid;
    logic [15:0]  exp_cnt;

    pkt_pattern_gen dut (
        .pktctrl_clk       (clk),
        .pktctrl_rstn      (rstn),
        .rf_self_test_mode (mode),
        .rf_96path_en      (en96),
        .rf_pattern_sel    (sel),
        .rf_pattern_fixed  (fixed),
        .rf_ramp_step      (step),
        .rf_pattern_hold   (hold),
        .pkt_gen_data      (data),
        .pkt_gen_valid     (valid),
        .pkt_gen_cnt       (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void build_prbs();
        logic [8:0] v;
        v = 9'h1FF;
        for (int i = 0; i < 511; i++) begin
            prbs_tab[i] = int'(v);
            v = {v[7:0], v[8] ^ v[4]};
        end
    endfunction

    function automatic logic [863:0] model_data();
        logic [863:0] d;
        int v;
        d = '0;
        if (mode) begin
            for (int p = 0; p < 96; p++) begin
                if (p < 48 || en96) begin
                    case (sel)
                        2'd0:    v = int'(fixed);
                        2'd1:    v = (m_base + p) % 512;
                        2'd2:    v = prbs_tab[m_n % 511] ^ p;
                        default: v = 1 << (m_n % 9);
                    endcase
                    d[p*9 +: 9] = 9'(v);
                end
            end
        end
        return d;
    endfunction

    function automatic int first_diff(logic [863:0] a, logic [863:0] b);
        for (int p = 0; p < 96; p++)
            if (a[p*9 +: 9] !== b[p*9 +: 9]) return p;
        return -1;
    endfunction

    function automatic void model_reset();
        m_n = 0; m_base = 0; m_cnt = 0; m_en_q = 1'b0; m_sel_q = 2'd0;
        exp_data = '0; exp_valid = 1'b0; exp_cnt = 16'd0;
    endfunction

    // Apply current inputs for one clock, advance the model, sample after the edge.
    task automatic clk_cycle();
        bit restart;
        restart = mode && (!m_en_q || sel != m_sel_q);
        if (restart) begin
            m_n = 0; m_base = 0; m_cnt = 0;
        end else if (mode && !hold) begin
            m_n++;
            m_base = (m_base + int'(step)) % 512;
            m_cnt  = (m_cnt + 1) % 65536;
        end
        m_en_q    = mode;
        m_sel_q   = sel;
        exp_valid = mode;
        exp_cnt   = 16'(m_cnt);
        exp_data  = model_data();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0; mode = 1'b0; en96 = 1'b1; sel = 2'd0;
        fixed = 9'd0; step = 9'd0; hold = 1'b0;
        model_reset();
        #12;
        n_chk++; if (data !== '0) $display("FAIL reset_data got %h want 0", data[35:0]); else n_pass++;
        n_chk++; if (valid !== 1'b0) $display("FAIL reset_valid got %b want 0", valid); else n_pass++;
        n_chk++; if (cnt !== 16'd0) $display("FAIL reset_cnt got %0d want 0", cnt); else n_pass++;
        rstn = 1'b1;
        clk_cycle();
        n_chk++; if (valid !== 1'b0 || data !== '0) $display("FAIL idle_out got valid %b want 0", valid); else n_pass++;
    endtask

    task automatic test_ramp();
        logic [35:0] want;
        mode = 1'b1; sel = 2'd1; step = 9'd1; hold = 1'b0; en96 = 1'b1;
        clk_cycle();
        want = {9'd3, 9'd2, 9'd1, 9'd0};
        n_chk++; if (data[35:0] !== want) $display("FAIL ramp_lane0_first got %h want %h", data[35:0], want); else n_pass++;
        want = {9'd95, 9'd94, 9'd93, 9'd92};
        n_chk++; if (data[863:828] !== want) $display("FAIL ramp_lane23_first got %h want %h", data[863:828], want); else n_pass++;
        n_chk++; if (valid !== 1'b1) $display("FAIL ramp_valid got %b want 1", valid); else n_pass++;
        n_chk++; if (cnt !== 16'd0) $display("FAIL ramp_cnt0 got %0d want 0", cnt); else n_pass++;
        clk_cycle();
        want = {9'd4, 9'd3, 9'd2, 9'd1};
        n_chk++; if (data[35:0] !== want) $display("FAIL ramp_lane0_second got %h want %h", data[35:0], want); else n_pass++;
        want = {9'd96, 9'd95, 9'd94, 9'd93};
        n_chk++; if (data[863:828] !== want) $display("FAIL ramp_lane23_second got %h want %h", data[863:828], want); else n_pass++;
        n_chk++; if (cnt !== 16'd1) $display("FAIL ramp_cnt1 got %0d want 1", cnt); else n_pass++;
        n_chk++; if (data !== exp_data) $display("FAIL ramp_model path %0d got %h want %h", first_diff(data, exp_data), data[first_diff(data, exp_data)*9 +: 9], exp_data[first_diff(data, exp_data)*9 +: 9]); else n_pass++;
    endtask

    task automatic test_ramp_wrap();
        int w [4];
        w = '{0, 200, 400, 88};
        mode = 1'b0;
        clk_cycle();
        mode = 1'b1; step = 9'd200;
        for (int i = 0; i < 4; i++) begin
            clk_cycle();
            n_chk++; if (data[8:0] !== 9'(w[i])) $display("FAIL ramp_wrap_%0d got %0d want %0d", i, data[8:0], w[i]); else n_pass++;
            n_chk++; if (data !== exp_data) $display("FAIL ramp_wrap_model_%0d path %0d mismatched", i, first_diff(data, exp_data)); else n_pass++;
        end
    endtask

    task automatic test_prbs();
        logic [8:0] seen [512];
        int rep;
        sel = 2'd2;
        for (int i = 0; i < 512; i++) begin
            clk_cycle();
            seen[i] = data[8:0];
            n_chk++; if (data[8:0] !== exp_data[8:0]) $display("FAIL prbs_p0_%0d got %h want %h", i, data[8:0], exp_data[8:0]); else n_pass++;
            n_chk++; if (data[8:0] === 9'd0) $display("FAIL prbs_zero_%0d got 0 want nonzero", i); else n_pass++;
            n_chk++; if (data[53:45] !== (data[8:0] ^ 9'd5)) $display("FAIL prbs_p5_%0d got %h want %h", i, data[53:45], data[8:0] ^ 9'd5); else n_pass++;
        end
        n_chk++; if (seen[0] !== 9'h1FF) $display("FAIL prbs_first got %h want 1ff", seen[0]); else n_pass++;
        rep = -1;
        for (int i = 1; i < 512; i++)
            if (rep < 0 && seen[i] === seen[0]) rep = i;
        n_chk++; if (rep != 511) $display("FAIL prbs_period got %0d want 511", rep); else n_pass++;
    endtask

    task automatic test_walk_hold();
        sel = 2'd3;
        for (int i = 0; i < 5; i++) begin
            clk_cycle();
            n_chk++; if (data[8:0] !== 9'(1 << i)) $display("FAIL walk_%0d got %h want %h", i, data[8:0], 9'(1 << i)); else n_pass++;
        end
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            clk_cycle();
            n_chk++; if (data[8:0] !== 9'h010) $display("FAIL hold_val_%0d got %h want 010", i, data[8:0]); else n_pass++;
            n_chk++; if (cnt !== 16'd4) $display("FAIL hold_cnt_%0d got %0d want 4", i, cnt); else n_pass++;
            n_chk++; if (valid !== 1'b1) $display("FAIL hold_valid_%0d got %b want 1", i, valid); else n_pass++;
        end
        hold = 1'b0;
        for (int i = 5; i < 10; i++) begin
            clk_cycle();
            n_chk++; if (data[8:0] !== 9'(1 << (i % 9))) $display("FAIL walk_%0d got %h want %h", i, data[8:0], 9'(1 << (i % 9))); else n_pass++;
        end
        n_chk++; if (cnt !== 16'd9) $display("FAIL walk_cnt got %0d want 9", cnt); else n_pass++;
    endtask

    task automatic test_lane_mask();
        logic [35:0] full;
        full = {4{9'h155}};
        sel = 2'd0; fixed = 9'h155; en96 = 1'b0;
        clk_cycle();
        for (int l = 0; l < 24; l++) begin
            n_chk++;
            if (data[l*36 +: 36] !== (l < 12 ? full : 36'd0))
                $display("FAIL mask_lane%0d got %h want %h", l, data[l*36 +: 36], (l < 12 ? full : 36'd0));
            else n_pass++;
        end
        en96 = 1'b1;
        clk_cycle();
        for (int l = 12; l < 24; l++) begin
            n_chk++; if (data[l*36 +: 36] !== full) $display("FAIL unmask_lane%0d got %h want %h", l, data[l*36 +: 36], full); else n_pass++;
        end
    endtask

    task automatic test_sel_change_hold();
        sel = 2'd1; step = 9'($urandom_range(1, 511));
        for (int i = 0; i < 5; i++) clk_cycle();
        n_chk++; if (cnt !== 16'd4) $display("FAIL pre_switch_cnt got %0d want 4", cnt); else n_pass++;
        sel = 2'd2; hold = 1'b1;
        clk_cycle();
        n_chk++; if (data[8:0] !== 9'h1FF) $display("FAIL switch_p0 got %h want 1ff", data[8:0]); else n_pass++;
        n_chk++; if (data[17*9 +: 9] !== (9'h1FF ^ 9'd17)) $display("FAIL switch_p17 got %h want %h", data[17*9 +: 9], 9'h1FF ^ 9'd17); else n_pass++;
        n_chk++; if (cnt !== 16'd0) $display("FAIL switch_cnt got %0d want 0", cnt); else n_pass++;
        n_chk++; if (data !== exp_data) $display("FAIL switch_model path %0d mismatched", first_diff(data, exp_data)); else n_pass++;
        hold = 1'b0;
    endtask

    task automatic test_disable();
        clk_cycle();
        clk_cycle();
        mode = 1'b0;
        clk_cycle();
        n_chk++; if (data !== '0) $display("FAIL disable_data got %h want 0", data[35:0]); else n_pass++;
        n_chk++; if (valid !== 1'b0) $display("FAIL disable_valid got %b want 0", valid); else n_pass++;
        n_chk++; if (cnt !== 16'd2) $display("FAIL disable_cnt got %0d want 2", cnt); else n_pass++;
        mode = 1'b1;
        clk_cycle();
        n_chk++; if (cnt !== 16'd0 || data[8:0] !== 9'h1FF) $display("FAIL reenable got cnt %0d p0 %h want 0 1ff", cnt, data[8:0]); else n_pass++;
    endtask

    task automatic test_random();
        int d;
        for (int i = 0; i < 400; i++) begin
            mode = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 19) == 0) sel = 2'($urandom);
            hold = ($urandom_range(0, 5) == 0);
            en96 = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 9) == 0) fixed = 9'($urandom);
            if ($urandom_range(0, 9) == 0) step = 9'($urandom);
            clk_cycle();
            d = first_diff(data, exp_data);
            n_chk++; if (d >= 0) $display("FAIL rand_data_%0d path %0d got %h want %h", i, d, data[d*9 +: 9], exp_data[d*9 +: 9]); else n_pass++;
            n_chk++; if (valid !== exp_valid) $display("FAIL rand_valid_%0d got %b want %b", i, valid, exp_valid); else n_pass++;
            n_chk++; if (cnt !== exp_cnt) $display("FAIL rand_cnt_%0d got %0d want %0d", i, cnt, exp_cnt); else n_pass++;
        end
    endtask

    task automatic test_async_reset();
        mode = 1'b1; sel = 2'd1; step = 9'd7; hold = 1'b0; en96 = 1'b1;
        for (int i = 0; i < 3; i++) clk_cycle();
        #2;
        rstn = 1'b0;
        #1;
        n_chk++; if (data !== '0) $display("FAIL async_data got %h want 0", data[35:0]); else n_pass++;
        n_chk++; if (valid !== 1'b0) $display("FAIL async_valid got %b want 0", valid); else n_pass++;
        n_chk++; if (cnt !== 16'd0) $display("FAIL async_cnt got %0d want 0", cnt); else n_pass++;
        model_reset();
        #3;
        rstn = 1'b1;
        clk_cycle();
        n_chk++; if (data !== exp_data || cnt !== 16'd0) $display("FAIL post_reset cnt %0d p0 %h want 0 %h", cnt, data[8:0], exp_data[8:0]); else n_pass++;
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        build_prbs();
        test_reset();
        test_ramp();
        test_ramp_wrap();
        test_prbs();
        test_walk_hold();
        test_lane_mask();
        test_sel_change_hold();
        test_disable();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
